// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
// Optional access-fault checking is enabled with MEM_ALIGN_CHECK_EN.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int unsigned DEF_SRAM_ADDR_LEN = 18;
  localparam int unsigned DEF_SRAM_DATA_LEN = 16;
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_addr_map.sv
// CPU byte address to SRAM halfword-pair translation.
// Fault flag port exists only when MEM_ALIGN_CHECK_EN is defined.
module mem_addr_map
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic [ADDRESS_LEN-1:0]   address,
  output logic [SRAM_ADDR_LEN-2:0] off
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                     fault
`endif
);

  logic [ADDRESS_LEN-1:0] rel;
  logic unused_rel;

  assign rel = address - BASE_ADDR;
  // word offset; halfword select is appended by the controller
  assign off = rel[SRAM_ADDR_LEN:2];
  assign unused_rel = ^{rel[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], rel[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = (address[1:0] != 2'b00) || (address < BASE_ADDR);
`endif

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit load/store as two 16-bit SRAM accesses with wait states.
// Define MEM_ALIGN_CHECK_EN to fault misaligned or below-base addresses.
module mem_stage_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
  parameter int unsigned SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [DATA_LEN-1:0]      wdata,
  output logic [DATA_LEN-1:0]      rdata,
  output logic                     ready,
  output logic                     err,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_o,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_i,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
);

  localparam int unsigned SD = SRAM_DATA_LEN;
  localparam logic [CNT_W-1:0] WAIT = CNT_W'(WAIT_CYCLES);

  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SRAM_ADDR_LEN-2:0] off, off_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic st_q;
  logic req;
  logic accept;
  logic cap_lo;
  logic cap_hi;
  logic fault;

  // no request is accepted while reset is held
  assign req = (rd_en | wr_en) & rst;

  mem_addr_map #(
    .ADDRESS_LEN  (ADDRESS_LEN),
    .SRAM_ADDR_LEN(SRAM_ADDR_LEN),
    .BASE_ADDR    (BASE_ADDR)
  ) u_map (
    .address(address),
    .off    (off)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .fault  (fault)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign fault = 1'b0;
`endif

  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    accept = 1'b0;
    cap_lo = 1'b0;
    cap_hi = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (fault) begin
            nxt = DONE;
          end else begin
            nxt = LO;
            cnt_nxt = WAIT;
          end
        end
      end
      LO: begin
        if (cnt == '0) begin
          nxt = HI;
          cnt_nxt = WAIT;
          cap_lo = ~st_q;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HI: begin
        if (cnt == '0) begin
          nxt = DONE;
          cap_hi = ~st_q;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      off_q <= '0;
      wdata_q <= '0;
      st_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (accept) begin
        off_q <= off;
        wdata_q <= wdata;
        st_q <= wr_en;
      end
      if (cap_lo) rdata[SD-1:0] <= sram_dq_i;
      if (cap_hi) rdata[2*SD-1:SD] <= sram_dq_i;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic flt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flt_q <= 1'b0;
    end else if (accept) begin
      flt_q <= fault;
    end
  end

  assign err = (state == DONE) & flt_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    sram_addr = '0;
    sram_dq_o = '0;
    sram_dq_oe = 1'b0;
    sram_we_n = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {off_q, state == HI};
      if (st_q) begin
        sram_dq_oe = 1'b1;
        sram_we_n = 1'b0;
        sram_dq_o = (state == HI) ? wdata_q[2*SD-1:SD]
                                  : wdata_q[SD-1:0];
      end
    end
  end

  assign ready = (state == IDLE && !req) || state == DONE;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench: W=1 instance (a) and W=0 instance (b) sharing clk/rst.
// Build with MEM_ALIGN_CHECK_EN to exercise the fault path.
module tb_mem_stage_sram_ctrl;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_rd, a_wr, a_ready, a_err, a_oe, a_we_n;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [17:0] a_saddr;
  logic [15:0] a_dq_o, a_dq_i;
  logic b_rd, b_wr, b_ready, b_err, b_oe, b_we_n;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [17:0] b_saddr;
  logic [15:0] b_dq_o, b_dq_i;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(a_rd), .wr_en(a_wr),
    .address(a_addr), .wdata(a_wdata), .rdata(a_rdata),
    .ready(a_ready), .err(a_err), .sram_addr(a_saddr),
    .sram_dq_o(a_dq_o), .sram_dq_i(a_dq_i),
    .sram_dq_oe(a_oe), .sram_we_n(a_we_n)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(b_rd), .wr_en(b_wr),
    .address(b_addr), .wdata(b_wdata), .rdata(b_rdata),
    .ready(b_ready), .err(b_err), .sram_addr(b_saddr),
    .sram_dq_o(b_dq_o), .sram_dq_i(b_dq_i),
    .sram_dq_oe(b_oe), .sram_we_n(b_we_n)
  );

  // SRAM models
  logic [15:0] a_mem [0:255];
  logic [15:0] b_mem [0:255];
  assign a_dq_i = a_mem[a_saddr[7:0]];
  assign b_dq_i = b_mem[b_saddr[7:0]];
  always @(posedge clk) if (!a_we_n) a_mem[a_saddr[7:0]] <= a_dq_o;
  always @(posedge clk) if (!b_we_n) b_mem[b_saddr[7:0]] <= b_dq_o;

  logic sel = 1'b0;
  logic v_ready, v_err, v_oe, v_we_n;
  logic [31:0] v_rdata;
  logic [17:0] v_saddr;
  logic [15:0] v_dq_o;
  assign v_ready = sel ? b_ready : a_ready;
  assign v_err = sel ? b_err : a_err;
  assign v_oe = sel ? b_oe : a_oe;
  assign v_we_n = sel ? b_we_n : a_we_n;
  assign v_rdata = sel ? b_rdata : a_rdata;
  assign v_saddr = sel ? b_saddr : a_saddr;
  assign v_dq_o = sel ? b_dq_o : a_dq_o;

  int tests = 0;
  int fails = 0;
  beat_t beat_q[$];
  logic [31:0] rd_q[$];
  logic [17:0] addr_seen[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd [0:1];

  task automatic run_op(input logic s, input logic wr,
                        input logic [31:0] addr, input logic [31:0] d);
    logic flt;
    logic [31:0] off;
    logic [31:0] exp_rd;
    int w, exp_done, done, strobes;
    logic err_seen;
    beat_t bt;
    w = s ? 0 : 1;
`ifdef MEM_ALIGN_CHECK_EN
    flt = (addr[1:0] != 2'b00) || (addr < 32'd1024);
`else
    flt = 1'b0;
`endif
    off = (addr - 32'd1024) >> 2;
    exp_done = flt ? 1 : 2 * w + 3;
    @(posedge clk);
    #1;
    sel = s;
    if (s) begin
      b_wr = wr; b_rd = ~wr; b_addr = addr; b_wdata = d;
    end else begin
      a_wr = wr; a_rd = ~wr; a_addr = addr; a_wdata = d;
    end
    if (!flt && wr) begin
      for (int k = 0; k <= w; k++) beat_q.push_back('{{off[16:0], 1'b0}, d[15:0]});
      for (int k = 0; k <= w; k++) beat_q.push_back('{{off[16:0], 1'b1}, d[31:16]});
      ref_mem[off] = d;
    end
    if (!flt && !wr) last_rd[s] = ref_mem[off];
    rd_q.push_back(last_rd[s]);
    addr_seen.delete();
    done = -1;
    strobes = 0;
    err_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0 && !v_ready) addr_seen.push_back(v_saddr);
      if (!v_we_n) begin
        strobes++;
        tests++;
        if (beat_q.size() == 0) begin
          fails++;
          $display("FAIL strobe: unexpected write addr=%0h data=%h", v_saddr, v_dq_o);
        end else begin
          bt = beat_q.pop_front();
          if (v_saddr !== bt.a || v_dq_o !== bt.d || v_oe !== 1'b1) begin
            fails++;
            $display("FAIL beat: got addr=%0h data=%h oe=%b want addr=%0h data=%h oe=1",
                     v_saddr, v_dq_o, v_oe, bt.a, bt.d);
          end
        end
      end
      if (v_ready) begin
        done = i;
        err_seen = v_err;
        break;
      end
    end
    if (s) begin b_wr = 0; b_rd = 0; end else begin a_wr = 0; a_rd = 0; end
    tests++;
    if (done !== exp_done) begin
      fails++;
      $display("FAIL latency: ready in cycle %0d, want %0d", done, exp_done);
    end
    tests++;
    if (err_seen !== flt) begin
      fails++;
      $display("FAIL err: got %b want %b", err_seen, flt);
    end
    exp_rd = rd_q.pop_front();
    tests++;
    if (v_rdata !== exp_rd) begin
      fails++;
      $display("FAIL rdata: got %h want %h", v_rdata, exp_rd);
    end
    tests++;
    if (wr && !flt ? beat_q.size() != 0 : strobes != 0) begin
      fails++;
      $display("FAIL strobes: count %0d, pending beats %0d, want no extra/missing",
               strobes, beat_q.size());
      beat_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_rd = 1; a_wr = 0; a_addr = 32'd1024; a_wdata = 0;
    b_rd = 1; b_wr = 0; b_addr = 32'd1024; b_wdata = 0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (a_ready !== 1'b1 || a_we_n !== 1'b1 || a_rdata !== 32'h0) begin
        fails++;
        $display("FAIL reset: ready=%b we_n=%b rdata=%h want 1 1 0", a_ready, a_we_n, a_rdata);
      end
    end
    @(posedge clk);
    #1;
    a_rd = 0; b_rd = 0; rst = 1'b1;
    last_rd[0] = 0; last_rd[1] = 0;
    @(negedge clk);
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_after_reset: ready a=%b b=%b want 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_store_load();
    run_op(0, 1, 32'd1024, 32'hDEADBEEF);
    run_op(0, 0, 32'd1024, 32'h0);
    tests++;
    if (addr_seen.size() != 4 || addr_seen[0] !== 18'd0 || addr_seen[1] !== 18'd0 ||
        addr_seen[2] !== 18'd1 || addr_seen[3] !== 18'd1) begin
      fails++;
      $display("FAIL load_addr_w1: seq size %0d, want 0,0,1,1", addr_seen.size());
    end
  endtask

  task automatic test_w0();
    run_op(1, 1, 32'd1028, 32'h12345678);
    run_op(1, 0, 32'd1028, 32'h0);
    tests++;
    if (addr_seen.size() != 2 || addr_seen[0] !== 18'd2 || addr_seen[1] !== 18'd3) begin
      fails++;
      $display("FAIL load_addr_w0: seq size %0d, want 2,3", addr_seen.size());
    end
  endtask

  task automatic test_misaligned();
    run_op(0, 0, 32'd1026, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(0, 1, 32'd1020, 32'h55555555);
`endif
  endtask

  task automatic test_back_to_back();
    run_op(0, 1, 32'd1036, 32'hCAFEF00D);
    run_op(0, 0, 32'd1036, 32'h0);
    run_op(0, 1, 32'd1040, 32'h0BADF00D);
    run_op(0, 0, 32'd1040, 32'h0);
  endtask

  task automatic test_reset_mid();
    run_op(0, 1, 32'd1032, 32'h11112222);
    @(posedge clk);
    #1;
    sel = 0;
    a_wr = 1; a_addr = 32'd1032; a_wdata = 32'hAAAABBBB;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_wr = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (a_we_n !== 1'b1 || a_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: we_n=%b ready=%b want 1 1", a_we_n, a_ready);
    end
    @(negedge clk);
    tests++;
    if (a_we_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_hold: we_n=%b want 1", a_we_n);
    end
    last_rd[0] = 0;
    last_rd[1] = 0;
    ref_mem[32'd2] = 32'h1111BBBB;
    run_op(0, 0, 32'd1032, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_w0();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage controller between the EX/MEM pipeline register and the off-chip 16-bit SRAM. Takes the registered ALU result as a byte address, Val_Rm as store data, and the MEM_R_EN/MEM_W_EN strobes. Performs each 32-bit load or store as two 16-bit SRAM accesses with programmable wait states. Holds `ready` low while busy so the hazard/freeze logic stalls the pipeline.

## Interface
- DATA_LEN, 32, CPU word width
- ADDRESS_LEN, 32, CPU byte-address width
- SRAM_ADDR_LEN, 18, SRAM halfword-address width
- SRAM_DATA_LEN, 16, SRAM data width
- BASE_ADDR, 32'd1024, first CPU byte address mapped to SRAM halfword 0
- WAIT_CYCLES, 1, extra cycles per halfword access (0..7)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- rd_en  in  1  load request (MEM_R_EN from EX/MEM register)
- wr_en  in  1  store request (MEM_W_EN from EX/MEM register)
- address  in  ADDRESS_LEN  byte address (ALU_Res)
- wdata  in  DATA_LEN  store data (Val_Rm)
- rdata  out  DATA_LEN  load result, registered
- ready  out  1  1 = stage can advance; 0 = freeze pipeline
- err  out  1  access-fault pulse (see Configuration)
- sram_addr  out  SRAM_ADDR_LEN  SRAM halfword address
- sram_dq_o  out  SRAM_DATA_LEN  SRAM write data
- sram_dq_i  in  SRAM_DATA_LEN  SRAM read data
- sram_dq_oe  out  1  1 = controller drives SRAM data bus
- sram_we_n  out  1  SRAM write strobe, active low

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE: on rd_en|wr_en, latch address, wdata, and op into internal registers, then go to LO. wr_en has priority when both are asserted.
- Address map: off = (address − BASE_ADDR) >> 2. LO uses sram_addr = {off, 1'b0}; HI uses {off, 1'b1}. Truncate to SRAM_ADDR_LEN.
- LO/HI each last WAIT_CYCLES+1 cycles, tracked by a 3-bit down-counter. Transition to the next state when the count is 0.
- Store: sram_dq_oe=1 for the whole LO/HI access. sram_dq_o = wdata[15:0] in LO and wdata[31:16] in HI. sram_we_n=0 for every cycle of LO/HI.
- Load: sram_dq_oe=0, sram_we_n=1. sram_dq_i is sampled on the last cycle of LO into rdata[15:0] and on the last cycle of HI into rdata[31:16].
- DONE: lasts one cycle, then return to IDLE. Requests seen in DONE are ignored; the pipeline has advanced by then.
- ready = (IDLE && !(rd_en|wr_en)) || DONE. This is combinational from state and request.
- rdata holds its value until the next load completes. Stores do not modify rdata.
- Outside LO/HI: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- Reset values: state IDLE, rdata 0, err 0, counter 0. Outputs settle to ready=1 (no request), sram_we_n=1, sram_dq_oe=0.
- Reset mid-access: abort immediately and do not update rdata. Drop sram_we_n to 1 on the same edge.

## Timing
- Request accepted in cycle 0 (IDLE; ready=0 that cycle).
- LO occupies cycles 1..W+1 and HI occupies cycles W+2..2W+2, where W=WAIT_CYCLES.
- DONE is cycle 2W+3: ready=1 and rdata valid.
- Total: 2W+4 cycles, with ready low for 2W+3 of them. W=1 gives 6 cycles.
- A back-to-back request, held by the frozen pipeline for the next instruction, is accepted in the IDLE cycle after DONE.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A request is a fault if address[1:0]≠0 or address<BASE_ADDR.
  - On a fault: IDLE goes straight to DONE. No SRAM cycle is issued and rdata is unchanged.
  - err=1 for the DONE cycle only.
- MEM_ALIGN_CHECK_EN undefined: address[1:0] is ignored, no range check is made, and err is tied to 0.

## Structure
- Package arm_mem_pkg holds:
  - the state enum {IDLE, LO, HI, DONE}
  - BASE_ADDR, SRAM_ADDR_LEN, and SRAM_DATA_LEN defaults
  - the counter width constant
- Sub-module mem_addr_map: combinational byte-address → SRAM halfword translation, plus the fault flag when MEM_ALIGN_CHECK_EN is defined.

## Test plan
- Reset held for 3 cycles with rd_en=1 → ready stays 1 (no request is accepted), sram_we_n=1, rdata=0.
- Store address=1024, wdata=32'hDEADBEEF, W=1 → sram_addr=0/data 16'hBEEF with we_n low for 2 cycles, then addr 1/data 16'hDEAD for 2 cycles; ready high in cycle 5.
- Load address=1024 from the SRAM model → rdata=32'hDEADBEEF in cycle 5, with ready low for cycles 0–4.
- Load address=1028, W=0 → sram_addr 2 then 3; total 4 cycles.
- rst asserted in cycle 2 of a store → on the next edge, state IDLE and sram_we_n=1; the HI half is never written.
- With MEM_ALIGN_CHECK_EN, load address=1026 → no SRAM strobe, err=1 and ready=1 in cycle 1, rdata unchanged.
